// File: rtl/wb_req_rr_arbiter_if.sv
// wb_req_rr_arbiter_if: request/response bundle between the writeback request
//   sources, the arbiter and the writeback unit. Fields are packed per requester,
//   requester i at [i*W +: W]. slave = arbiter view, master = source/sink view.
// Signals: in_valid/in_ready (per requester), in_bits_{tag,idx,param,way_en},
//   out_valid/out_ready, out_bits_{tag,idx,param,way_en}, out_chosen.
interface wb_req_rr_arbiter_if #(
  parameter int N_IN    = 8,
  parameter int TAG_W   = 20,
  parameter int IDX_W   = 6,
  parameter int PARAM_W = 3,
  parameter int WAY_W   = 8
);
  localparam int CW = ($clog2(N_IN) > 1) ? $clog2(N_IN) : 1;

  // Request side, one lane per requester
  logic [N_IN-1:0]         in_valid;
  logic [N_IN-1:0]         in_ready;
  logic [N_IN*TAG_W-1:0]   in_bits_tag;
  logic [N_IN*IDX_W-1:0]   in_bits_idx;
  logic [N_IN*PARAM_W-1:0] in_bits_param;
  logic [N_IN*WAY_W-1:0]   in_bits_way_en;

  // Registered output toward the writeback unit
  logic                    out_valid;
  logic                    out_ready;
  logic [TAG_W-1:0]        out_bits_tag;
  logic [IDX_W-1:0]        out_bits_idx;
  logic [PARAM_W-1:0]      out_bits_param;
  logic [WAY_W-1:0]        out_bits_way_en;
  logic [CW-1:0]           out_chosen;

  // Arbiter side
  modport slave (
    input  in_valid, in_bits_tag, in_bits_idx, in_bits_param, in_bits_way_en,
    input  out_ready,
    output in_ready,
    output out_valid, out_bits_tag, out_bits_idx, out_bits_param, out_bits_way_en,
    output out_chosen
  );

  // Requester / sink side
  modport master (
    output in_valid, in_bits_tag, in_bits_idx, in_bits_param, in_bits_way_en,
    output out_ready,
    input  in_ready,
    input  out_valid, out_bits_tag, out_bits_idx, out_bits_param, out_bits_way_en,
    input  out_chosen
  );
endinterface

// File: rtl/wb_req_rr_arbiter.sv
// wb_req_rr_arbiter: N-way writeback/release request arbiter, round-robin or fixed priority.
// Latency: 1 cycle from input handshake to out_valid (registered output stage), 1 req/cycle.
// Backpressure: out_valid held with out_ready low stalls everything; no requester sees ready.
// Ports: clk_i (rising edge), rst_i (async active-high), req_if (slave modport):
//   in_valid/in_ready/in_bits_* per requester, out_valid/out_ready/out_bits_*/out_chosen.
module wb_req_rr_arbiter #(
  parameter int N_IN    = 8,
  parameter int TAG_W   = 20,
  parameter int IDX_W   = 6,
  parameter int PARAM_W = 3,
  parameter int WAY_W   = 8,
  parameter int RR      = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  wb_req_rr_arbiter_if.slave    req_if
);
  localparam int CW = ($clog2(N_IN) > 1) ? $clog2(N_IN) : 1;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   idx;
    logic [PARAM_W-1:0] param;
    logic [WAY_W-1:0]   way_en;
  } wb_req_t;

  // State
  logic [CW-1:0] last_q,      last_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] chosen_q,    chosen_d;
  wb_req_t       req_q,       req_d;

  // Arbitration results
  logic [CW-1:0]   cand;
  logic [CW-1:0]   win_idx;
  logic            win_any;
  logic [N_IN-1:0] win_oh;
  wb_req_t         win_req;
  logic            can_load;
  logic            load;

  // Priority search. In round-robin mode the scan begins just after the last
  // granted index and wraps; in fixed mode it always begins at index 0.
  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    cand    = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (RR != 0) begin
        cand = CW'((int'(last_q) + 1 + k) % N_IN);
      end else begin
        cand = CW'(k);
      end
      if (!win_any && req_if.in_valid[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    win_oh = '0;
    if (win_any) begin
      win_oh[win_idx] = 1'b1;
    end
  end

  // Payload mux for the winning lane
  always_comb begin
    win_req        = '0;
    win_req.tag    = req_if.in_bits_tag   [int'(win_idx)*TAG_W   +: TAG_W];
    win_req.idx    = req_if.in_bits_idx   [int'(win_idx)*IDX_W   +: IDX_W];
    win_req.param  = req_if.in_bits_param [int'(win_idx)*PARAM_W +: PARAM_W];
    win_req.way_en = req_if.in_bits_way_en[int'(win_idx)*WAY_W   +: WAY_W];
  end

  // The output register can take a new request when empty or draining this cycle.
  assign can_load = ~out_valid_q | req_if.out_ready;
  assign load     = can_load & win_any;

  // Only the winner sees ready; reset gating keeps ready low while the
  // register is being cleared so no source believes it was accepted.
  assign req_if.in_ready = win_oh & {N_IN{can_load & ~rst_i}};

  // Next state
  always_comb begin
    last_d      = last_q;
    out_valid_d = out_valid_q;
    chosen_d    = chosen_q;
    req_d       = req_q;
    if (load) begin
      // Load wins over unload: a simultaneous drain and refill keeps valid high.
      out_valid_d = 1'b1;
      req_d       = win_req;
      chosen_d    = win_idx;
      if (RR != 0) begin
        last_d = win_idx;
      end
    end else if (out_valid_q && req_if.out_ready) begin
      // Payload and chosen are left as-is after the drain.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // last = N_IN-1 gives index 0 first priority out of reset.
      last_q      <= CW'(N_IN - 1);
      out_valid_q <= 1'b0;
      chosen_q    <= '0;
      req_q       <= '0;
    end else begin
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      chosen_q    <= chosen_d;
      req_q       <= req_d;
    end
  end

  // Outputs come straight from registers
  assign req_if.out_valid       = out_valid_q;
  assign req_if.out_bits_tag    = req_q.tag;
  assign req_if.out_bits_idx    = req_q.idx;
  assign req_if.out_bits_param  = req_q.param;
  assign req_if.out_bits_way_en = req_q.way_en;
  assign req_if.out_chosen      = chosen_q;

endmodule

// File: doc/wb_req_rr_arbiter.md
# wb_req_rr_arbiter

Parametrised N-way arbiter for data-cache writeback/release requests (tag, idx, param, way_en), the next generation of the fixed 8-input priority arbiter in front of the writeback unit. It adds three things:
- selectable round-robin or fixed-priority arbitration;
- a registered output stage that breaks the combinational valid→data path;
- a reported grant index.

It sits between the MSHR/prober request sources and the writeback unit, and sustains one request per cycle.

## Interface
Parameters:
- N_IN, 8: number of requesters, 2..16.
- TAG_W, 20: tag width.
- IDX_W, 6: set index width.
- PARAM_W, 3: TileLink shrink/report param width.
- WAY_W, 8: one-hot way enable width.
- RR, 1: 1 = round-robin, 0 = fixed priority (index 0 highest).
- CW, derived = max(1, $clog2(N_IN)).

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- io_in_valid  in  N_IN  per-requester valid.
- io_in_ready  out  N_IN  per-requester ready.
- io_in_bits_tag  in  N_IN*TAG_W  requester i occupies bits [i*TAG_W +: TAG_W]; same packing for the three fields below.
- io_in_bits_idx  in  N_IN*IDX_W.
- io_in_bits_param  in  N_IN*PARAM_W.
- io_in_bits_way_en  in  N_IN*WAY_W.
- io_out_ready  in  1  downstream ready.
- io_out_valid  out  1  registered valid.
- io_out_bits_tag / _idx / _param / _way_en  out  TAG_W / IDX_W / PARAM_W / WAY_W  registered payload.
- io_out_chosen  out  CW  index of the requester whose payload is in the output register.

## Operation

**Arbitration (combinational)**
- The winner is chosen among asserted io_in_valid bits.
- RR=0: lowest asserted index wins.
- RR=1: search starts at (last+1) mod N_IN, ascending and wrapping; the first asserted index wins.
- last is a CW-bit register, reset to N_IN-1, so index 0 has top priority after reset.

**Load condition and ready**
- can_load = ~out_valid_q | io_out_ready.
- io_in_ready[i] = can_load & win[i]. Only the winner ever sees ready.
- Inputs must not withdraw valid or change bits while valid & ~ready; the arbiter may re-pick among them next cycle.

**Load**
- A load occurs when can_load & |io_in_valid.
- On a load, the output register captures the winner's four fields and its index into io_out_chosen, and sets out_valid_q=1.
- If RR=1, last <= the winner index. last updates only on a load, never on valid alone.

**Unload**
- On io_out_valid & io_out_ready with no load in the same cycle, out_valid_q <= 0. Payload and chosen hold their values.

**Simultaneous events**
- Unload and load in the same cycle: the register is replaced with the new winner and io_out_valid stays 1. This gives full throughput.

**Backpressure**
- out_valid_q=1 and io_out_ready=0: all io_in_ready = 0 and the register and last hold.

## Timing
- Latency: exactly 1 cycle from the input handshake to io_out_valid.
- Throughput: 1 request/cycle while io_out_ready=1.
- Combinational paths:
  - io_out_ready → io_in_ready: permitted, one AND level past the arbiter.
  - io_in_valid → io_in_ready: permitted, the arbiter tree.
  - No combinational path from any input to io_out_*.
- Reset values: io_out_valid=0, io_out_bits_* = 0, io_out_chosen=0, last=N_IN-1.
- io_in_ready is 0 while reset is asserted.
- Reset asserted mid-transfer: the output register is cleared asynchronously and the held request is dropped. Requesters re-present after reset, and the arbiter then behaves as from power-on.
- RR fairness: with all N_IN requesters continuously valid and the sink always ready, every index is granted exactly once in any N_IN consecutive grants.

## Test plan
- Reset then a single request:
  - Stimulus: in 3 valid, tag=0xABCDE, idx=0x15, param=2, way_en=0x10, out_ready=1.
  - Response: io_in_ready[3]=1 in cycle 0. Next cycle io_out_valid=1, chosen=3 and the exact fields. Then io_out_valid=0 once in 3 drops.
- RR=1, all 8 valid, out_ready=1 for 10 cycles → chosen sequence 0,1,2,3,4,5,6,7,0,1 (each on the cycle after its load).
- RR=0, all 8 valid for 4 cycles → chosen 0,0,0,0, and io_in_ready[7:1] stay 0 throughout.
- Backpressure:
  - Stimulus: load from input 5, hold out_ready=0 for 3 cycles with inputs 2 and 6 valid.
  - Response: output frozen at chosen=5, io_in_ready=0, last unchanged.
  - Then out_ready=1 → next loaded chosen=6 with RR=1 (search starts at 6), or 2 with RR=0.
- Back-to-back: inputs 1 and 4 valid, out_ready=1 → loads on consecutive cycles, io_out_valid high 2 cycles with no bubble, chosen 1 then 4.
- Asynchronous reset asserted mid-cycle while io_out_valid=1 → io_out_valid=0 immediately, without waiting for a clock edge. After release, the first contest between 0 and 7 grants 0.
